// File: rtl/heading_pid_if.sv
// Heading controller bus: heading sample and command inputs from the
// inertial/command layers, wheel speed commands out to the motor drive.
interface heading_pid_if;
  logic               rdy;
  logic signed [11:0] heading;
  logic signed [11:0] dsrd_hdng;
  logic               moving;
  logic        [9:0]  frwrd;
  logic signed [10:0] lft_spd;
  logic signed [10:0] rght_spd;
  logic               out_vld;

  modport master (
    output rdy, heading, dsrd_hdng, moving, frwrd,
    input  lft_spd, rght_spd, out_vld
  );

  modport slave (
    input  rdy, heading, dsrd_hdng, moving, frwrd,
    output lft_spd, rght_spd, out_vld
  );
endinterface

// File: rtl/heading_pid.sv
// Closed-loop heading PID controller producing left/right wheel speeds.
// Pipeline: capture heading error, saturate it, form P/I/D terms, then
// combine and apply to the forward speed. out_vld fires on the third edge
// after the edge that sampled rdy; every rdy produces exactly one out_vld.
// Optional feature: define INTEG_SAT_EN to make the integrator saturate at
// the 16-bit signed limits instead of wrapping.
module heading_pid #(
  parameter logic [3:0]  P_COEFF = 4'h3,
  parameter logic [4:0]  D_COEFF = 5'h0E,
  parameter int unsigned I_SHIFT = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  heading_pid_if.slave bus
);

  // Stage 0: raw heading error (12-bit wrap gives the shortest angle).
  logic signed [11:0] err_raw_d, err_raw_q;
  logic               v0_q;
  // Stage 1: error saturated to 10 bits.
  logic signed [9:0]  err_d, err_q;
  logic               v1_q;
  // Stage 2: P/I/D terms plus controller state.
  logic signed [9:0]  prev_d, prev_q;
  logic signed [15:0] integ_d, integ_q, integ_acc;
  logic signed [10:0] diff_full;
  logic signed [6:0]  diff_sat;
  logic signed [13:0] p_d, i_d, d_d, p_q, i_q, d_q;
  logic               v2_q, mv2_q;
  // Stage 3: combined correction applied to forward speed.
  logic signed [13:0] sum;
  logic signed [11:0] adj, fwd, lft_full, rght_full;
  logic signed [10:0] lft_d, rght_d, lft_q, rght_q;
  logic               vld_q;
`ifdef INTEG_SAT_EN
  logic signed [16:0] integ_sum;
`endif

  function automatic logic signed [10:0] sat11(input logic signed [11:0] x);
    if (x > 12'sd1023)       return 11'h3FF;
    else if (x < -12'sd1024) return 11'h400;
    else                     return x[10:0];
  endfunction

  assign err_raw_d = bus.heading - bus.dsrd_hdng;

  // Stage 1 saturation of the raw error to [-512, 511].
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    err_d = err_raw_q[9:0];
    if (err_raw_q > 12'sd511)       err_d = 10'h1FF;
    else if (err_raw_q < -12'sd512) err_d = 10'h200;
  end

  // Stage 2 arithmetic: P, saturated derivative, integrator update and I.
  always_comb begin
    diff_full = 11'(err_q) - 11'(prev_q);
    diff_sat  = diff_full[6:0];
    if (diff_full > 11'sd63)       diff_sat = 7'h3F;
    else if (diff_full < -11'sd64) diff_sat = 7'h40;

    p_d = 14'(err_q) * $signed(14'(P_COEFF));
    d_d = 14'(diff_sat) * $signed(14'(D_COEFF));

`ifdef INTEG_SAT_EN
    integ_sum = 17'(integ_q) + 17'(err_q);
    integ_acc = integ_sum[15:0];
    if (integ_sum > 17'sd32767)       integ_acc = 16'h7FFF;
    else if (integ_sum < -17'sd32768) integ_acc = 16'h8000;
`else
    integ_acc = integ_q + 16'(err_q);
`endif
    i_d = 14'(integ_acc >>> I_SHIFT);

    // Stopping clears controller memory so a restart does not inherit windup.
    integ_d = integ_q;
    prev_d  = prev_q;
    if (!bus.moving) begin
      integ_d = '0;
      prev_d  = '0;
    end else if (v1_q) begin
      integ_d = integ_acc;
      prev_d  = err_q;
    end
  end

  // Stage 3 arithmetic: floor-scaled correction, differential wheel speeds.
  always_comb begin
    sum       = p_q + i_q + d_q;
    adj       = 12'(sum >>> 3);
    fwd       = $signed({2'b00, bus.frwrd});
    lft_full  = fwd + adj;
    rght_full = fwd - adj;
    lft_d     = sat11(lft_full);
    rght_d    = sat11(rght_full);
  end

  // Stages 0 and 1 registers: error capture and saturated error.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_raw_q <= '0;
      v0_q      <= 1'b0;
      err_q     <= '0;
      v1_q      <= 1'b0;
    end else begin
      v0_q <= bus.rdy;
      v1_q <= v0_q;
      if (bus.rdy) err_raw_q <= err_raw_d;
      if (v0_q)    err_q     <= err_d;
    end
  end

  // Stage 2 registers: PID terms, integrator and previous error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q     <= '0;
      i_q     <= '0;
      d_q     <= '0;
      mv2_q   <= 1'b0;
      v2_q    <= 1'b0;
      integ_q <= '0;
      prev_q  <= '0;
    end else begin
      v2_q    <= v1_q;
      integ_q <= integ_d;
      prev_q  <= prev_d;
      if (v1_q) begin
        p_q   <= p_d;
        i_q   <= i_d;
        d_q   <= d_d;
        mv2_q <= bus.moving;
      end
    end
  end

  // Stage 3 registers: wheel speeds held between updates, one-shot valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_q  <= '0;
      rght_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      vld_q <= v2_q;
      if (v2_q) begin
        lft_q  <= (bus.moving && mv2_q) ? lft_d  : '0;
        rght_q <= (bus.moving && mv2_q) ? rght_d : '0;
      end
    end
  end

  assign bus.lft_spd  = lft_q;
  assign bus.rght_spd = rght_q;
  assign bus.out_vld  = vld_q;

endmodule

// File: tb/tb_heading_pid.sv
// Self-checking bench for heading_pid: directed steps, expected wheel speeds
// queued at drive time and compared when out_vld fires.
module tb_heading_pid;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  heading_pid_if bus();
  heading_pid dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic signed [10:0] l;
    logic signed [10:0] r;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_integ = 0;
  int   m_prev  = 0;

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int x, input int lo, input int hi);
    return (x < lo) ? lo : ((x > hi) ? hi : x);
  endfunction

  // Integer reference of the controller with moving=1.
  task automatic model_step(input logic [11:0] h, input logic [11:0] d, input int fw,
                            output int l, output int r);
    logic signed [11:0] raw;
    int e, p, dd, i, s, a;
    raw = h - d;
    e = sat(int'(raw), -512, 511);
    p = 3 * e;
    dd = 14 * sat(e - m_prev, -64, 63);
    m_prev = e;
    m_integ = m_integ + e;
`ifdef INTEG_SAT_EN
    m_integ = sat(m_integ, -32768, 32767);
`else
    if (m_integ > 32767)       m_integ = m_integ - 65536;
    else if (m_integ < -32768) m_integ = m_integ + 65536;
`endif
    i = m_integ >>> 6;
    s = p + i + dd;
    a = s >>> 3;
    l = sat(fw + a, -1024, 1023);
    r = sat(fw - a, -1024, 1023);
  endtask

  task automatic push(input int l, input int r);
    exp_t e;
    e.l = 11'(l);
    e.r = 11'(r);
    sb_q.push_back(e);
  endtask

  task automatic push_model(input logic [11:0] h, input logic [11:0] d);
    int l, r;
    model_step(h, d, int'(bus.frwrd), l, r);
    push(l, r);
  endtask

  // Hand-derived expectation; the model still advances its state.
  task automatic push_const(input logic [11:0] h, input logic [11:0] d, input int l, input int r);
    int ml, mr;
    model_step(h, d, int'(bus.frwrd), ml, mr);
    push(l, r);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse(input logic [11:0] h, input logic [11:0] d);
    bus.heading   = h;
    bus.dsrd_hdng = d;
    bus.rdy       = 1'b1;
    tick();
    bus.rdy       = 1'b0;
  endtask

  task automatic wait_vld(input string tag);
    bit seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.out_vld === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check(tag, bus.out_vld, 1'b1);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.rdy = 1'b0;
    repeat (2) tick();
    check("rst_lft", bus.lft_spd, 0);
    check("rst_rght", bus.rght_spd, 0);
    check("rst_vld", bus.out_vld, 0);
    sb_q.delete();
    m_integ = 0;
    m_prev  = 0;
    rst_n   = 1'b1;
    tick();
  endtask

  // Scoreboard monitor: every out_vld must match the oldest queued result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.out_vld === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("spurious_vld", bus.out_vld, 0);
      end else begin
        mon_e = sb_q.pop_front();
        check("lft_spd", bus.lft_spd, mon_e.l);
        check("rght_spd", bus.rght_spd, mon_e.r);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.rdy       = 1'b0;
    bus.heading   = '0;
    bus.dsrd_hdng = '0;
    bus.moving    = 1'b1;
    bus.frwrd     = 10'h100;
    do_reset();

    // Basic: exact latency, one-shot valid, outputs hold.
    push_const(12'h010, 12'h000, 290, 222);
    pulse(12'h010, 12'h000);
    check("lat_e0", bus.out_vld, 0);
    tick();
    check("lat_e1", bus.out_vld, 0);
    tick();
    check("lat_e2", bus.out_vld, 0);
    tick();
    check("lat_e3", bus.out_vld, 1);
    tick();
    check("vld_oneshot", bus.out_vld, 0);
    repeat (3) tick();
    check("hold_lft", bus.lft_spd, 290);
    check("hold_rght", bus.rght_spd, 222);

    // Error saturation.
    do_reset();
    push_const(12'h400, 12'h000, 558, -46);
    pulse(12'h400, 12'h000);
    wait_vld("vld_errsat");

    // Heading wrap-around.
    do_reset();
    push_const(12'h7F0, 12'h810, 187, 325);
    pulse(12'h7F0, 12'h810);
    wait_vld("vld_wrap");

    // Stopped robot: outputs forced to zero, controller memory cleared.
    push_model(12'h400, 12'h000);
    pulse(12'h400, 12'h000);
    wait_vld("vld_premove");
    bus.moving = 1'b0;
    m_integ = 0;
    m_prev  = 0;
    push(0, 0);
    pulse(12'h123, 12'h000);
    wait_vld("vld_stopped");
    bus.moving = 1'b1;
    push_const(12'h010, 12'h000, 290, 222);
    pulse(12'h010, 12'h000);
    wait_vld("vld_restart");

    // Integrator limit with full forward speed.
    do_reset();
    bus.frwrd     = 10'h3FF;
    bus.heading   = 12'h400;
    bus.dsrd_hdng = 12'h000;
    bus.rdy       = 1'b1;
    for (int k = 0; k < 80; k++) begin
      push_model(12'h400, 12'h000);
      tick();
    end
    bus.rdy = 1'b0;
    repeat (6) tick();
    check("integ_lim_lft", bus.lft_spd, 1023);
`ifdef INTEG_SAT_EN
    check("integ_lim_rght", bus.rght_spd, 768);
`else
    check("integ_lim_rght", bus.rght_spd, 880);
`endif

    // Back-to-back samples produce back-to-back results in order.
    bus.frwrd = 10'h100;
    push_model(12'h020, 12'h000);
    push_model(12'hFE0, 12'h000);
    push_model(12'h005, 12'h000);
    bus.rdy = 1'b1;
    bus.heading = 12'h020;
    tick();
    bus.heading = 12'hFE0;
    tick();
    bus.heading = 12'h005;
    tick();
    bus.rdy = 1'b0;
    wait_vld("vld_b2b");
    tick();
    check("b2b_vld2", bus.out_vld, 1);
    tick();
    check("b2b_vld3", bus.out_vld, 1);
    tick();
    check("b2b_end", bus.out_vld, 0);

    // Reset with samples in flight: nothing emerges afterwards.
    bus.rdy = 1'b1;
    bus.heading = 12'h100;
    tick();
    tick();
    bus.rdy = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_lft", bus.lft_spd, 0);
    check("midrst_rght", bus.rght_spd, 0);
    check("midrst_vld", bus.out_vld, 0);
    m_integ = 0;
    m_prev  = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("postrst_vld", bus.out_vld, 0);
    end
    check("postrst_lft", bus.lft_spd, 0);

    check("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
